// File: rtl/adc_fifo_pkg.sv
// Shared types and constant helpers for the ADC sample FIFO with read sequencer.
package adc_fifo_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_FETCH  = 4'b0010,
        ST_STROBE = 4'b0100,
        ST_GAP    = 4'b1000
    } state_t;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of a counter running 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/adc_fifo_seq_if.sv
// Bundle of the write-side, read-side and status signals of adc_fifo_seq.
interface adc_fifo_seq_if #(
    parameter int DATA_W = 16,
    parameter int AW     = 8,
    parameter int BL_W   = 4
);
    // wren is a per-cycle valid for wrdata and is accepted only while full=0;
    // rden is a request accepted only while busy=0, and each delivered word is
    // marked by rdstb=0 with rddata held stable for the whole low phase.
    logic [DATA_W-1:0] wrdata;
    logic              wren;
    logic              rden;
    logic [BL_W-1:0]   burst_len;
    logic              clr_err;
    logic [DATA_W-1:0] rddata;
    logic              rdstb;
    logic              busy;
    logic              full;
    logic              afull;
    logic              empty;
    logic [AW:0]       level;
    logic              ovf;
    logic              udf;
    logic [3:0]        dbg_state;

    modport master (
        output wrdata, wren, rden, burst_len, clr_err,
        input  rddata, rdstb, busy, full, afull, empty, level, ovf, udf, dbg_state
    );

    modport slave (
        input  wrdata, wren, rden, burst_len, clr_err,
        output rddata, rdstb, busy, full, afull, empty, level, ovf, udf, dbg_state
    );

endinterface

// File: rtl/adc_fifo_mem.sv
// Simple dual-port sample RAM: synchronous write, registered read with an enable.
module adc_fifo_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int AW     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    // The output register only loads on a read, so it holds the last word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/adc_fifo_seq.sv
// ADC sample FIFO with a burst read sequencer driving an active-low read strobe.
module adc_fifo_seq
    import adc_fifo_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 256,
    parameter int AFULL_TH = 240,
    parameter int STB_LEN  = 2,
    parameter int BL_W     = 4
) (
    input  logic          clk,
    input  logic          reset,
    adc_fifo_seq_if.slave bus
);

    localparam int AW  = clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int SCW = cnt_w(STB_LEN);

    state_t            r_state;
    state_t            w_next;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [BL_W-1:0]   r_remaining;
    logic [SCW-1:0]    r_stb_cnt;
    logic              r_rdstb;
    logic              r_busy;
    logic              r_ovf;
    logic              r_udf;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_load;
    logic              w_dec;
    logic              w_udf_evt;
    logic              w_ovf_evt;
    logic [DATA_W-1:0] w_rddata;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = bus.wren & ~w_full;
    assign w_ovf_evt = bus.wren & w_full;
    assign w_pop     = (r_state == ST_FETCH);

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_dec     = 1'b0;
        w_udf_evt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.rden) begin
                    if (!w_empty) begin
                        w_load = 1'b1;
                        w_next = ST_FETCH;
                    end else begin
                        w_udf_evt = 1'b1;
                    end
                end
            end
            ST_FETCH:  w_next = ST_STROBE;
            ST_STROBE: begin
                if (r_stb_cnt == SCW'(STB_LEN - 1)) w_next = ST_GAP;
            end
            ST_GAP: begin
                if (r_remaining == '0) begin
                    w_next = ST_IDLE;
                end else if (!w_empty) begin
                    w_dec  = 1'b1;
                    w_next = ST_FETCH;
                end else begin
                    // Burst ran dry: truncate and flag it.
                    w_udf_evt = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_remaining <= '0;
            r_stb_cnt   <= '0;
            r_rdstb     <= 1'b1;
            r_busy      <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_load)     r_remaining <= bus.burst_len;
            else if (w_dec) r_remaining <= r_remaining - 1'b1;
            r_stb_cnt <= (r_state == ST_STROBE) ? r_stb_cnt + 1'b1 : '0;
            // Strobe and busy come from the next state so they are plain flops.
            r_rdstb <= (w_next != ST_STROBE);
            r_busy  <= (w_next != ST_IDLE);
            r_ovf   <= w_ovf_evt | (r_ovf & ~bus.clr_err);
            r_udf   <= w_udf_evt | (r_udf & ~bus.clr_err);
        end
    end

    adc_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wrdata),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rddata)
    );

    assign bus.rddata    = w_rddata;
    assign bus.rdstb     = r_rdstb;
    assign bus.busy      = r_busy;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.afull     = (r_level >= LW'(AFULL_TH));
    assign bus.level     = r_level;
    assign bus.ovf       = r_ovf;
    assign bus.udf       = r_udf;
    assign bus.dbg_state = r_state;

endmodule

// File: doc/adc_fifo_seq.md
# adc_fifo_seq

Parametrised single-clock ADC sample FIFO with a built-in read sequencer. It is the next generation of the 256x16 ADC sampling FIFO. It adds:
- configurable width, depth and almost-full threshold
- burst reads of up to 2^BL_W words per request
- a configurable-length active-low read strobe
- an exact fill level
- sticky overflow/underflow flags

It sits between the ADC capture logic (write side) and the host/bus read-out logic (strobe side).

## Interface
Parameters:
- DATA_W, 16, sample width in bits
- DEPTH, 256, FIFO depth in words; power of 2, at least 4; AW = log2(DEPTH)
- AFULL_TH, 240, almost-full threshold in words; 1 to DEPTH
- STB_LEN, 2, number of cycles rdstb is held low per word; at least 1
- BL_W, 4, width of burst_len

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-low reset
- wrdata  in  DATA_W  sample to write
- wren  in  1  write enable; one word per cycle while high
- rden  in  1  read request; sampled only in IDLE
- burst_len  in  BL_W  words per request = burst_len+1; sampled with rden
- clr_err  in  1  clears ovf and udf
- rddata  out  DATA_W  registered read word
- rdstb  out  1  active-low read strobe; rddata is stable while it is low
- busy  out  1  high whenever the state is not IDLE
- full, afull, empty  out  1  status flags
- level  out  AW+1  current word count, 0 to DEPTH
- ovf, udf  out  1  sticky error flags

## Operation
- Storage: circular buffer with AW-bit read/write pointers that wrap from DEPTH-1 to 0. level is an AW+1-bit counter.
- Write: when wren=1 and full=0, store wrdata, advance the write pointer and increment level.
- Write while full: when wren=1 and full=1, the word is dropped and ovf is set. This holds even if a pop happens in the same cycle.
- Flags:
  - full = (level==DEPTH)
  - empty = (level==0)
  - afull = (level>=AFULL_TH)
  - All three are combinational from level.
- Simultaneous push and pop: level is unchanged.
- Read state machine, one-hot encoded:
  - IDLE: if rden=1 and empty=0, load remaining=burst_len and go to FETCH. If rden=1 and empty=1, set udf and stay in IDLE.
  - FETCH: pop one word into rddata at the end of the cycle, then go to STROBE.
  - STROBE: rdstb=0 for STB_LEN cycles (counter), then go to GAP.
  - GAP: rdstb=1 for one cycle.
    - If remaining==0, go to IDLE.
    - Else if empty=0, decrement remaining and go to FETCH.
    - Else set udf and go to IDLE (the burst is truncated).
- Error flags: clr_err=1 clears ovf and udf. If an error event occurs in the same cycle as clr_err, the set wins.
- Reset values (asynchronous, while reset=0):
  - state=IDLE, pointers and level=0
  - rddata=0, rdstb=1, busy=0
  - ovf=0, udf=0, empty=1, full=0, afull=0
  - FIFO contents are discarded.
- Reset mid-burst: the burst is aborted immediately and rdstb returns to 1 asynchronously.

## Timing
- rden=1 in IDLE at cycle n, with empty=0:
  - FETCH at n+1
  - rddata valid from n+2
  - rdstb low during n+2 .. n+1+STB_LEN
  - GAP at n+2+STB_LEN
- Per-word period within a burst: STB_LEN+2 cycles.
- A new request is accepted at the earliest 1 cycle after GAP.
- Write-to-empty deassert latency: 1 cycle. A word written at edge k gives empty=0 after edge k.
- rddata changes only at the end of FETCH. It holds through STROBE, GAP and IDLE.
- rdstb and busy are registered and glitch-free.

## Structure
- Package adc_fifo_pkg holds:
  - the state localparams (IDLE/FETCH/STROBE/GAP, 4-bit one-hot)
  - the log2 helper function for AW and the strobe counter width
- Sub-module adc_fifo_mem: DEPTH x DATA_W simple dual-port RAM with synchronous write and synchronous registered read, so it maps to block RAM.
- Pointers, level, flags and the state machine live in the top level.

## Test plan
- Reset: hold reset=0 with wren=1 → empty=1, level=0, rdstb=1, rddata=0; no writes accepted.
- Single read:
  - Stimulus: DATA_W=16, STB_LEN=2; write 0x1234, then rden with burst_len=0.
  - Required: rddata=0x1234 two cycles after rden; rdstb low for exactly 2 cycles; empty=1 afterwards; busy low after GAP.
- Burst with wrap:
  - Stimulus: DEPTH=8. Write 6 words, read 6, then write 0xA0..0xA7 (8 words).
  - Required: full=1, level=8, afull per threshold.
  - Then rden with burst_len=7: expect the 8 words in order, rdstb period 4 cycles, empty=1.
- Overflow: write 9 words into DEPTH=8 → the 9th is dropped, ovf=1, level=8. clr_err → ovf=0.
- Underflow:
  - rden on empty → udf=1, no strobe.
  - Burst of 4 with only 2 words stored → 2 strobes, then udf=1, IDLE.
- Concurrency and reset:
  - Simultaneous wren and pop at level=3 → level stays 3.
  - Assert reset during STROBE → rdstb=1 immediately, level=0.
